// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen: parametrised Fibonacci LFSR (XOR or XNOR feedback) with step
// enable, runtime seed load, lock-up detection with automatic recovery and a
// one-cycle pulse when the sequence returns to its start value.
//
// Optional feature macro: LFSR_STEP_CNT_EN adds the step_cnt output, a count
// of enabled steps since the last reset/load/wrap.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous reset, active-high (out <= SEED)
//   en       - advance one step per cycle while high
//   load     - load seed_in this cycle (wins over en)
//   seed_in  - runtime seed value
//   out      - current LFSR state (registered)
//   lockup   - high while out equals the lock-up state (decode of out)
//   wrap     - registered pulse, out has returned to the start value
//   step_cnt - enabled step count (LFSR_STEP_CNT_EN only)
// ---------------------------------------------------------------------------
module lfsr_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'hC),
  parameter bit               XNOR  = 1'b1,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             lockup,
  output logic             wrap
`ifdef LFSR_STEP_CNT_EN
  ,
  output logic [CNT_W-1:0] step_cnt
`endif
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
    $error("lfsr_gen: WIDTH must be 2..32 and CNT_W at least 1");
  end

  // The single state the feedback function maps onto itself.
  localparam logic [WIDTH-1:0] LOCK = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q,  wrap_d;
  logic             fb;
  logic [WIDTH-1:0] step_val;

  // Next value for an enabled step: normal shift, or bit-0 flip out of lock-up.
  always_comb begin
    fb       = (^(out_q & TAPS)) ^ XNOR;
    step_val = {out_q[WIDTH-2:0], fb};
    if (out_q == LOCK) begin
      step_val = out_q ^ WIDTH'(1);
    end
  end

  // Next state: load > en > hold (reset handled in the register).
  always_comb begin
    out_d   = out_q;
    start_d = start_q;
    wrap_d  = 1'b0;
    if (load) begin
      out_d   = seed_in;
      start_d = seed_in;
    end else if (en) begin
      out_d  = step_val;
      wrap_d = (step_val == start_q);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= SEED;
      start_q <= SEED;
      wrap_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      start_q <= start_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out    = out_q;
  assign wrap   = wrap_q;
  assign lockup = (out_q == LOCK);

`ifdef LFSR_STEP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts enabled steps; restarts at zero on load and on the wrap step.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap_d ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen: self-checking bench for lfsr_gen. Two instances (default
// 4-bit XNOR and 8-bit XOR maximal-length) share the control inputs; a
// behavioural model tracks both and is compared on every falling edge, while
// directed phases pin the model with hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [3:0] seed_a;
  logic [7:0] seed_b;
  logic [3:0] a_out;
  logic       a_lockup, a_wrap;
  logic [7:0] b_out;
  logic       b_lockup, b_wrap;
`ifdef LFSR_STEP_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_gen u_dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_a),
    .out(a_out), .lockup(a_lockup), .wrap(a_wrap)
`ifdef LFSR_STEP_CNT_EN
    , .step_cnt(a_cnt)
`endif
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .XNOR(1'b0), .SEED(8'h01)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_b),
    .out(b_out), .lockup(b_lockup), .wrap(b_wrap)
`ifdef LFSR_STEP_CNT_EN
    , .step_cnt(b_cnt)
`endif
  );

  // Behavioural next value: parity of tapped bits, optionally inverted,
  // shifted in at bit 0; the lock-up value escapes by flipping bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int unsigned w,
                                            input logic [31:0] taps, input bit xn);
    logic [31:0] mask;
    logic [31:0] lock;
    int unsigned par;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    lock = xn ? mask : 32'd0;
    if (s == lock) return s ^ 32'd1;
    par = ($countones(s & taps) + (xn ? 1 : 0)) % 2;
    return ((s << 1) | par) & mask;
  endfunction

  // Reference model state for both instances.
  logic [3:0]  ma_out, ma_start;
  logic        ma_wrap;
  logic [7:0]  mb_out, mb_start;
  logic        mb_wrap;
  logic [15:0] ma_cnt, mb_cnt;
  bit          mdl_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] na;
    logic [7:0] nb;
    na = 4'(lfsr_next(32'(ma_out), 4, 32'hC, 1'b1));
    nb = 8'(lfsr_next(32'(mb_out), 8, 32'hB8, 1'b0));
    if (rst) begin
      ma_out <= 4'h0;  ma_start <= 4'h0;  ma_wrap <= 1'b0; ma_cnt <= 16'd0;
      mb_out <= 8'h01; mb_start <= 8'h01; mb_wrap <= 1'b0; mb_cnt <= 16'd0;
      mdl_valid <= 1'b1;
    end else if (load) begin
      ma_out <= seed_a; ma_start <= seed_a; ma_wrap <= 1'b0; ma_cnt <= 16'd0;
      mb_out <= seed_b; mb_start <= seed_b; mb_wrap <= 1'b0; mb_cnt <= 16'd0;
    end else if (en) begin
      ma_out  <= na;
      ma_wrap <= (na == ma_start);
      ma_cnt  <= (na == ma_start) ? 16'd0 : ma_cnt + 16'd1;
      mb_out  <= nb;
      mb_wrap <= (nb == mb_start);
      mb_cnt  <= (nb == mb_start) ? 16'd0 : mb_cnt + 16'd1;
    end else begin
      ma_wrap <= 1'b0;
      mb_wrap <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("a_out",    32'(a_out),    32'(ma_out));
      chk("a_lockup", 32'(a_lockup), 32'(ma_out == 4'hF));
      chk("a_wrap",   32'(a_wrap),   32'(ma_wrap));
      chk("b_out",    32'(b_out),    32'(mb_out));
      chk("b_lockup", 32'(b_lockup), 32'(mb_out == 8'h00));
      chk("b_wrap",   32'(b_wrap),   32'(mb_wrap));
`ifdef LFSR_STEP_CNT_EN
      chk("a_cnt", 32'(a_cnt), 32'(ma_cnt));
      chk("b_cnt", 32'(b_cnt), 32'(mb_cnt));
`endif
    end
  end

  // Apply one cycle of inputs; return just after the sampling edge.
  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic [3:0] sa, input logic [7:0] sb);
    rst = r; load = l; en = e; seed_a = sa; seed_b = sb;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_seq [16];
  bit         seen [256];

  initial begin
    exp_seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    rst = 1'b1; load = 1'b0; en = 1'b0; seed_a = '0; seed_b = '0;

    // Reset state.
    cyc(1, 0, 0, 4'h0, 8'h00);
    cyc(1, 0, 1, 4'h5, 8'h55);
    chk("rst_a_out", 32'(a_out), 32'h0);
    chk("rst_a_wrap", 32'(a_wrap), 32'h0);
    chk("rst_b_out", 32'(b_out), 32'h01);

    // Default full period from SEED=0.
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 0, 1, 4'h0, 8'h00);
      chk("seq_out", 32'(a_out), 32'(exp_seq[i]));
      chk("seq_wrap", 32'(a_wrap), 32'(i == 15));
      chk("seq_lockup", 32'(a_lockup), 32'h0);
`ifdef LFSR_STEP_CNT_EN
      chk("seq_cnt", 32'(a_cnt), (i == 15) ? 32'd0 : 32'(i));
`endif
    end

    // Lock-up seed and recovery; wrap never fires afterwards.
    cyc(0, 1, 0, 4'hF, 8'h00);
    chk("lock_out", 32'(a_out), 32'hF);
    chk("lock_flag", 32'(a_lockup), 32'h1);
    chk("lock_b_flag", 32'(b_lockup), 32'h1);
`ifdef LFSR_STEP_CNT_EN
    chk("load_cnt", 32'(a_cnt), 32'h0);
`endif
    cyc(0, 0, 1, 4'h0, 8'h00);
    chk("recov_out", 32'(a_out), 32'hE);
    chk("recov_flag", 32'(a_lockup), 32'h0);
    chk("recov_b_out", 32'(b_out), 32'h01);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 1, 4'h0, 8'h00);
      chk("lock_nowrap", 32'(a_wrap), 32'h0);
    end

    // Load wins over en; period 15 back to seed 6.
    cyc(0, 1, 1, 4'h6, 8'h37);
    chk("ld_en_out", 32'(a_out), 32'h6);
    chk("ld_en_wrap", 32'(a_wrap), 32'h0);
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 0, 1, 4'h0, 8'h00);
      chk("seed6_wrap", 32'(a_wrap), 32'(i == 15));
    end
    chk("seed6_out", 32'(a_out), 32'h6);

    // en toggling, then reset mid-sequence.
    cyc(1, 0, 0, 4'h0, 8'h00);
    cyc(0, 0, 1, 4'h0, 8'h00); chk("tog1", 32'(a_out), 32'h1);
    cyc(0, 0, 0, 4'h0, 8'h00); chk("tog2", 32'(a_out), 32'h1);
    chk("tog2_wrap", 32'(a_wrap), 32'h0);
    cyc(0, 0, 0, 4'h0, 8'h00); chk("tog3", 32'(a_out), 32'h1);
`ifdef LFSR_STEP_CNT_EN
    chk("hold_cnt", 32'(a_cnt), 32'h1);
`endif
    cyc(0, 0, 1, 4'h0, 8'h00); chk("tog4", 32'(a_out), 32'h3);
    cyc(0, 0, 1, 4'h0, 8'h00);
    cyc(1, 1, 1, 4'h9, 8'h99); chk("midrst", 32'(a_out), 32'h0);

    // 8-bit maximal-length period: distinct non-zero states, wrap at 255.
    cyc(1, 0, 0, 4'h0, 8'h00);
    foreach (seen[k]) seen[k] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      cyc(0, 0, 1, 4'h0, 8'h00);
      chk("b_nonzero", 32'(b_out != 8'h00), 32'h1);
      chk("b_wrap_lit", 32'(b_wrap), 32'(i == 255));
      if (i < 255) begin
        chk("b_distinct", 32'(seen[b_out]), 32'h0);
        seen[b_out] = 1'b1;
      end
    end
    chk("b_period_out", 32'(b_out), 32'h01);

    // Randomised traffic; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] sa;
      logic [7:0] sb;
      sa = 4'($urandom);
      sb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) sa = 4'hF;
      if ($urandom_range(0, 7) == 0) sb = 8'h00;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0), sa, sb);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
